// File: rtl/search_scheduler_if.sv
// Handshake bundle between the search scheduler and its cracker cores.
// The scheduler takes the slave side; whatever drives the cores takes the master side.
interface search_scheduler_if #(
   parameter int unsigned N_CORES = 4
);
   logic                      enable_switch;
   logic [N_CORES-1:0]        core_req;
   logic [N_CORES-1:0]        core_found;
   logic [32*N_CORES-1:0]     core_result;
   logic [N_CORES-1:0]        core_grant;
   logic [31:0]               core_base;
   logic [31:0]               target;
   logic                      status_paused;
   logic                      status_running;
   logic                      status_warming;
   logic                      status_found;
   logic                      status_done;

   modport master (
      output enable_switch, core_req, core_found, core_result,
      input  core_grant, core_base, target,
      input  status_paused, status_running, status_warming, status_found, status_done
   );

   modport slave (
      input  enable_switch, core_req, core_found, core_result,
      output core_grant, core_base, target,
      output status_paused, status_running, status_warming, status_found, status_done
   );
endinterface

// File: rtl/search_scheduler.sv
// Hands out 2^CHUNK_BITS-candidate chunks of the 32-bit key space to idle cores
// round-robin, and latches the first reported hit.
module search_scheduler #(
   parameter int unsigned N_CORES    = 4,
   parameter int unsigned CHUNK_BITS = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   search_scheduler_if.slave bus
);
   localparam int unsigned PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int unsigned CNT_W = $clog2(N_CORES + 1);

   localparam logic [2:0] S_WARMING = 3'd0;
   localparam logic [2:0] S_RUNNING = 3'd1;
   localparam logic [2:0] S_PAUSED  = 3'd2;
   localparam logic [2:0] S_FOUND   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [32:0]      CHUNK    = 33'd1 << CHUNK_BITS;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CORES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CORES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CORES - 1);

   logic [2:0]         state, state_next;
   logic [32:0]        next_base;
   logic [CNT_W-1:0]   grant_cnt;
   logic [PTR_W-1:0]   rr_ptr;
   logic [N_CORES-1:0] grant_q;
   logic [31:0]        base_q;
   logic [31:0]        target_q;

   logic [31:0]        result_arr [N_CORES];
   logic [N_CORES-1:0] eligible;
   logic [N_CORES-1:0] grant_vec;
   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx;
   int unsigned        scan_idx;
   logic               win_valid;
   logic [31:0]        win_result;
   logic               exhausted;
   logic               any_found;
   logic               active;
   logic               do_grant;

   for (genvar g = 0; g < N_CORES; g++) begin : g_slice
      assign result_arr[g] = bus.core_result[32*g +: 32];
   end

   assign exhausted = next_base[32];
   assign any_found = |bus.core_found;
   assign active    = (state == S_WARMING) || (state == S_RUNNING);
   // A core holding its grant pulse this cycle is not eligible again.
   assign eligible  = bus.core_req & ~grant_q;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int unsigned k = 0; k < N_CORES; k++) begin
         scan_idx = k + 32'(rr_ptr);
         if (scan_idx >= N_CORES) scan_idx = scan_idx - N_CORES;
         if (!pick_valid && eligible[PTR_W'(scan_idx)]) begin
            pick_valid = 1'b1;
            pick_idx   = PTR_W'(scan_idx);
         end
      end
   end

   always_comb begin
      win_valid  = 1'b0;
      win_result = '0;
      for (int unsigned k = 0; k < N_CORES; k++) begin
         if (!win_valid && bus.core_found[PTR_W'(k)]) begin
            win_valid  = 1'b1;
            win_result = result_arr[PTR_W'(k)];
         end
      end
   end

   always_comb begin
      grant_vec           = '0;
      grant_vec[pick_idx] = 1'b1;
   end

   assign do_grant = active && bus.enable_switch && !any_found && !exhausted && pick_valid;

   always_comb begin
      state_next = state;
      case (state)
         S_WARMING, S_RUNNING: begin
            if (any_found)                           state_next = S_FOUND;
            else if (!bus.enable_switch)             state_next = S_PAUSED;
            else if (exhausted && (&bus.core_req))   state_next = S_DONE;
            else if (do_grant && state == S_WARMING && grant_cnt == CNT_LAST)
                                                     state_next = S_RUNNING;
         end
         S_PAUSED: begin
            if (any_found)               state_next = S_FOUND;
            else if (bus.enable_switch)  state_next = (grant_cnt < CNT_FULL) ? S_WARMING : S_RUNNING;
         end
         default: state_next = state;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_WARMING;
         next_base <= '0;
         grant_cnt <= '0;
         rr_ptr    <= '0;
         grant_q   <= '0;
         base_q    <= '0;
         target_q  <= '0;
      end else begin
         state   <= state_next;
         grant_q <= '0;
         if (do_grant) begin
            grant_q   <= grant_vec;
            base_q    <= next_base[31:0];
            next_base <= next_base + CHUNK;
            if (grant_cnt != CNT_FULL) grant_cnt <= grant_cnt + 1'b1;
            rr_ptr    <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
         end
         if (win_valid && (active || state == S_PAUSED)) target_q <= win_result;
      end
   end

   assign bus.core_grant     = grant_q;
   assign bus.core_base      = base_q;
   assign bus.target         = target_q;
   assign bus.status_warming = (state == S_WARMING);
   assign bus.status_running = (state == S_RUNNING);
   assign bus.status_paused  = (state == S_PAUSED);
   assign bus.status_found   = (state == S_FOUND);
   assign bus.status_done    = (state == S_DONE);
endmodule

// File: tb/tb_search_scheduler.sv
// Bench for search_scheduler: directed scenarios plus random traffic against a
// cycle-level reference model; two extra instances cover key-space exhaustion.
module tb_search_scheduler;
   localparam int N  = 4;
   localparam int CB = 16;

   localparam int M_WARM  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_FOUND = 3;
   localparam int M_DONE  = 4;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   search_scheduler_if #(.N_CORES(4)) ifa ();
   search_scheduler_if #(.N_CORES(4)) ifb ();
   search_scheduler_if #(.N_CORES(8)) ifc ();

   search_scheduler #(.N_CORES(4), .CHUNK_BITS(16)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
   search_scheduler #(.N_CORES(4), .CHUNK_BITS(30)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));
   search_scheduler #(.N_CORES(8), .CHUNK_BITS(30)) dut_c (.CLK(CLK), .RESET(RESET), .bus(ifc));

   int n_vec;
   int n_err;

   // Reference model of instance A: key-space cursor as a plain integer.
   int          m_state, m_cnt, m_ptr, m_prev, m_gidx;
   longint      m_next;
   logic [31:0] m_base, m_target;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int c;
      if (RESET) begin
         m_state = M_WARM; m_cnt = 0; m_ptr = 0; m_prev = -1; m_gidx = -1;
         m_next = 0; m_base = '0; m_target = '0;
      end else begin
         m_gidx = -1;
         if (m_state == M_FOUND || m_state == M_DONE) begin
            // terminal until reset
         end else if (ifa.core_found != '0) begin
            for (int i = N - 1; i >= 0; i--)
               if (ifa.core_found[i]) m_target = ifa.core_result[32*i +: 32];
            m_state = M_FOUND;
         end else if (m_state == M_PAUSE) begin
            if (ifa.enable_switch) m_state = (m_cnt < N) ? M_WARM : M_RUN;
         end else if (!ifa.enable_switch) begin
            m_state = M_PAUSE;
         end else if (m_next >= 64'h1_0000_0000) begin
            if (&ifa.core_req) m_state = M_DONE;
         end else begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (m_gidx < 0 && ifa.core_req[c] && c != m_prev) m_gidx = c;
            end
            if (m_gidx >= 0) begin
               m_base = m_next[31:0];
               m_next = m_next + (longint'(1) << CB);
               if (m_cnt < N) m_cnt++;
               m_ptr = (m_gidx + 1) % N;
               if (m_state == M_WARM && m_cnt == N) m_state = M_RUN;
            end
         end
         m_prev = m_gidx;
      end
   endtask

   task automatic tick();
      logic [63:0] eg;
      logic [4:0]  es;
      model_step();
      @(posedge CLK);
      #1;
      eg = (m_gidx >= 0) ? (64'd1 << m_gidx) : 64'd0;
      es = 5'b10000 >> m_state;
      chk("a_grant", ifa.core_grant, eg);
      chk("a_status", {ifa.status_warming, ifa.status_running, ifa.status_paused,
                       ifa.status_found, ifa.status_done}, es);
      chk("a_target", ifa.target, m_target);
      if (m_gidx >= 0) chk("a_base", ifa.core_base, m_base);
   endtask

   initial begin
      logic [31:0] e;
      n_vec = 0;
      n_err = 0;
      RESET = 1'b1;
      ifa.enable_switch = 1'b0; ifa.core_req = '0; ifa.core_found = '0; ifa.core_result = '0;
      ifb.enable_switch = 1'b1; ifb.core_req = '1; ifb.core_found = '0; ifb.core_result = '0;
      ifc.enable_switch = 1'b1; ifc.core_req = '1; ifc.core_found = '0; ifc.core_result = '0;
      tick();
      tick();
      chk("rst_base", ifa.core_base, 64'd0);
      chk("rst_b_warming", ifb.status_warming, 64'd1);

      // Warm-up: all four cores requesting, plus exhaustion on B and C.
      RESET = 1'b0;
      ifa.enable_switch = 1'b1;
      ifa.core_req = '1;
      for (int i = 0; i < 4; i++) begin
         tick();
         e = 32'(i) << 16;
         chk("wu_grant", ifa.core_grant, 64'd1 << i);
         chk("wu_base", ifa.core_base, e);
         e = 32'(i) << 30;
         chk("ex_b_grant", ifb.core_grant, 64'd1 << i);
         chk("ex_b_base", ifb.core_base, e);
         chk("ex_c_grant", ifc.core_grant, 64'd1 << i);
         chk("ex_c_base", ifc.core_base, e);
      end
      chk("wu_running", ifa.status_running, 64'd1);
      chk("ex_c_warming", ifc.status_warming, 64'd1);
      tick();
      chk("ex_b_done", ifb.status_done, 64'd1);
      chk("ex_b_no5th", ifb.core_grant, 64'd0);
      chk("ex_c_done", ifc.status_done, 64'd1);
      chk("ex_c_no5th", ifc.core_grant, 64'd0);
      ifb.enable_switch = 1'b0;
      tick();
      chk("ex_b_hold", ifb.status_done, 64'd1);
      ifb.core_req = '0; ifc.core_req = '0;

      // Reset landing on a grant cycle while RUNNING.
      chk("mid_pre_grant", ifa.core_grant != '0, 64'd1);
      RESET = 1'b1;
      tick();
      chk("mid_grant", ifa.core_grant, 64'd0);
      chk("mid_warming", ifa.status_warming, 64'd1);
      chk("mid_target", ifa.target, 64'd0);
      RESET = 1'b0;
      tick();
      chk("mid_first_core", ifa.core_grant, 64'h1);
      chk("mid_first_base", ifa.core_base, 64'h0);

      // Round-robin skip: last grant core 1, only cores 3 and 1 requesting.
      tick();
      chk("rr_core1", ifa.core_grant, 64'h2);
      ifa.core_req = 4'b1010;
      tick();
      chk("rr_core3", ifa.core_grant, 64'h8);
      tick();
      chk("rr_core1_again", ifa.core_grant, 64'h2);

      // Pause after two grants, then resume in WARMING with core 2.
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      ifa.core_req = '1;
      tick();
      tick();
      ifa.enable_switch = 1'b0;
      tick();
      chk("pz_paused", ifa.status_paused, 64'd1);
      tick();
      tick();
      chk("pz_no_grant", ifa.core_grant, 64'd0);
      ifa.enable_switch = 1'b1;
      tick();
      chk("pz_warming", ifa.status_warming, 64'd1);
      tick();
      chk("pz_core2", ifa.core_grant, 64'h4);
      chk("pz_base2", ifa.core_base, 64'h0002_0000);

      // Random traffic against the model.
      for (int it = 0; it < 400; it++) begin
         RESET = ($urandom_range(0, 39) == 0);
         ifa.enable_switch = ($urandom_range(0, 7) != 0);
         ifa.core_req = 4'($urandom);
         ifa.core_found = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'b0000;
         for (int s = 0; s < N; s++) ifa.core_result[32*s +: 32] = $urandom;
         tick();
      end

      // Simultaneous hits on cores 1 and 2: lowest index wins, state frozen.
      RESET = 1'b1;
      ifa.core_found = '0;
      tick();
      RESET = 1'b0;
      ifa.enable_switch = 1'b1;
      ifa.core_req = '1;
      tick();
      tick();
      ifa.core_found = 4'b0110;
      ifa.core_result = {32'h0BAD_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_0000};
      tick();
      chk("fd_target", ifa.target, 64'hDEAD_BEEF);
      chk("fd_found", ifa.status_found, 64'd1);
      chk("fd_no_grant", ifa.core_grant, 64'd0);
      for (int it = 0; it < 6; it++) begin
         ifa.enable_switch = ~ifa.enable_switch;
         ifa.core_req = 4'($urandom);
         ifa.core_found = 4'($urandom);
         for (int s = 0; s < N; s++) ifa.core_result[32*s +: 32] = $urandom;
         tick();
         chk("fd_hold_target", ifa.target, 64'hDEAD_BEEF);
         chk("fd_hold_found", ifa.status_found, 64'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/search_scheduler.md
SEARCH_SCHEDULER -- requirements
Module: search_scheduler

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of cracker cores served.
REQ-002 SHALL have parameter CHUNK_BITS, default 16, log2 of candidates per dispatched chunk (range 1..31).
REQ-003 SHALL have port CLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable_switch  in  1  1 = dispatch allowed, 0 = pause.
REQ-006 SHALL have port core_req  in  N_CORES  core i idle and requesting a chunk.
REQ-007 SHALL have port core_found  in  N_CORES  core i hit, qualified by core_result slice i.
REQ-008 SHALL have port core_result  in  32*N_CORES  core i matching candidate, bits [32i+31:32i].
REQ-009 SHALL have port core_grant  out  N_CORES  one-cycle grant pulse, at most one bit set.
REQ-010 SHALL have port core_base  out  32  first candidate of the granted chunk, valid while any core_grant bit is high.
REQ-011 SHALL have port target  out  32  latched winning candidate.
REQ-012 SHALL have ports status_paused, status_running, status_warming, status_found, status_done  out  1 each  one-hot state indication.

Function
REQ-013 SHALL implement states WARMING, RUNNING, PAUSED, FOUND, DONE; exactly one status_* output high, matching the current state, every cycle.
REQ-014 SHALL keep a 33-bit next_base counter (reset 0), add 2^CHUNK_BITS on each grant; exhausted when bit 32 = 1.
REQ-015 SHALL keep a grant counter saturating at N_CORES (reset 0).
REQ-016 SHALL, in WARMING or RUNNING with enable_switch=1, no core_found bit set, and not exhausted, grant one requesting core per cycle, registered: core_grant and core_base = next_base[31:0] appear the cycle after the req is sampled.
REQ-017 SHALL arbitrate round-robin: search starts at the index after the last granted core (after reset: index 0), wrapping at N_CORES-1.
REQ-018 SHALL not grant the same core on two consecutive cycles; a core's req during its grant cycle is ignored.
REQ-019 SHALL move WARMING -> RUNNING when the grant counter reaches N_CORES.
REQ-020 SHALL move WARMING/RUNNING -> PAUSED when enable_switch=0, issuing no grants while PAUSED.
REQ-021 SHALL move PAUSED -> WARMING when enable_switch=1 and grant counter < N_CORES, else PAUSED -> RUNNING.
REQ-022 SHALL move WARMING/RUNNING/PAUSED -> FOUND on any core_found bit; lowest set index wins on simultaneous hits; target latches that core's result the same edge.
REQ-023 SHALL give core_found priority over granting: no grant is issued on the edge that enters FOUND.
REQ-024 SHALL move RUNNING -> DONE when exhausted and all core_req bits are 1 for one sampled cycle with no core_found.
REQ-025 SHALL also reach DONE from WARMING under the REQ-024 condition (N_CORES > number of chunks).
REQ-026 SHALL hold FOUND and DONE until RESET, ignoring enable_switch, core_req and core_found; target frozen.
REQ-027 SHALL never increment next_base past 2^32 and never grant when exhausted.

Reset
REQ-028 SHALL, on RESET=1 at a rising edge, set state WARMING, next_base 0, grant counter 0, round-robin pointer to index 0, core_grant 0, core_base 0, target 0.
REQ-029 SHALL take RESET priority over every other input, including mid-grant and in FOUND/DONE.
REQ-030 SHALL, after RESET, have status_warming=1 and all other status_* = 0.

Verification
REQ-031 Warm-up: defaults, enable=1, core_req=4'b1111 held -> grants to cores 0,1,2,3 on four consecutive cycles, core_base 0x00000000, 0x00010000, 0x00020000, 0x00030000; status_running=1 after the 4th.
REQ-032 Pause: enable=0 after 2 grants -> status_paused=1, no grants; enable=1 -> WARMING resumes with core 2, base 0x00020000.
REQ-033 Simultaneous found: core_found=4'b0110, core_result slices 1=0xDEADBEEF, 2=0x12345678 -> target=0xDEADBEEF, status_found=1, no grant that edge, holds with enable toggling.
REQ-034 Exhaustion: CHUNK_BITS=30, all req high -> 4 grants (bases 0x0, 0x40000000, 0x80000000, 0xC0000000), then status_done=1, no 5th grant.
REQ-035 Round-robin: only core_req[3] and core_req[1] high after last grant to core 1 -> next grant core 3, then core 1.
REQ-036 Reset mid-operation: RESET=1 in RUNNING during a grant cycle -> next cycle core_grant=0, target=0, status_warming=1; first grant after release goes to core 0, base 0.
